// File: rtl/polar_pkg.sv
// -----------------------------------------------------------------------------
// polar_pkg
// Shared types and helpers for the streaming polar encoder.
//   state_t     : LOAD (collect message beats), ENC (one butterfly stage per
//                 clock), OUT (emit codeword beats)
//   DEF_N/DEF_P : default codeword length and beat width
//   NSTAGES     : butterfly stages for the default codeword length
//   NBEATS      : beats per frame for the default configuration
//   bitrev_n    : reverse the low nbits bits of an index
//   stage_mask  : 1 when index i is the upper-half element of a stage-s pair
//   is_pow2     : elaboration-time parameter check
// -----------------------------------------------------------------------------
package polar_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ENC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int DEF_N   = 32;
  localparam int DEF_P   = 8;
  localparam int NSTAGES = $clog2(DEF_N);
  localparam int NBEATS  = DEF_N / DEF_P;

  function automatic int unsigned bitrev_n(input int unsigned idx, input int unsigned nbits);
    int unsigned r;
    r = 32'd0;
    for (int unsigned b = 32'd0; b < nbits; b++) begin
      r = (r << 1) | ((idx >> b) & 32'd1);
    end
    return r;
  endfunction

  function automatic logic stage_mask(input int s, input int i);
    return ~i[s];
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 32'sd0) && ((v & (v - 32'sd1)) == 32'sd0);
  endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// -----------------------------------------------------------------------------
// polar_butterfly_stage
// Combinational application of one polar butterfly stage to an N-bit frame:
// for every i with bit s clear, x[i] ^= x[i + 2^s]; all other bits pass.
//   i_x     : frame before the stage
//   i_stage : stage number s (0 .. log2(N)-1)
//   o_x     : frame after the stage
// -----------------------------------------------------------------------------
module polar_butterfly_stage
  import polar_pkg::*;
#(
  parameter int N  = 32,
  parameter int SW = 3
) (
  input  logic [N-1:0]  i_x,
  input  logic [SW-1:0] i_stage,
  output logic [N-1:0]  o_x
);

  localparam int NST = $clog2(N);

  // Exactly one s matches i_stage, so XOR-accumulating over s applies one stage.
  // For i with bit s clear, i ^ 2^s equals i + 2^s.
  always_comb begin
    o_x = i_x;
    for (int i = 0; i < N; i++) begin
      for (int s = 0; s < NST; s++) begin
        o_x[i] = o_x[i] ^ (((i_stage == SW'(s)) && stage_mask(s, i)) ? i_x[i ^ (1 << s)] : 1'b0);
      end
    end
  end

endmodule

// File: rtl/polar_encoder_stream.sv
// -----------------------------------------------------------------------------
// polar_encoder_stream
// Buffers an N-bit message arriving as N/P beats, encodes it in place with one
// butterfly stage per clock (x = u * F^(x)n, F = [[1,0],[1,1]]) and emits the
// codeword as N/P beats, optionally in bit-reversed order.
//   i_clk, i_rst_n         : clock, synchronous active-low reset
//   i_in_data/valid/last   : message beats, beat b = u[b*P +: P]
//   o_in_ready             : beat accepted this cycle (LOAD only)
//   o_out_data/valid/last  : codeword beats, o_out_last on beat N/P-1
//   i_out_ready            : downstream accepts the beat
//   o_frame_err            : one-cycle pulse when i_in_last disagrees with
//                            the beat count (the frame still encodes)
// All outputs are registered.
// -----------------------------------------------------------------------------
module polar_encoder_stream
  import polar_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int P      = DEF_P,
  parameter int BITREV = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [P-1:0] i_in_data,
  input  logic         i_in_valid,
  input  logic         i_in_last,
  output logic         o_in_ready,
  output logic [P-1:0] o_out_data,
  output logic         o_out_valid,
  output logic         o_out_last,
  input  logic         i_out_ready,
  output logic         o_frame_err
);

  localparam int NST = $clog2(N);
  localparam int NB  = N / P;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW  = (NST > 1) ? $clog2(NST) : 1;
  localparam logic [BW-1:0] LAST_BEAT  = BW'(NB - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NST - 1);

  if (!is_pow2(N) || (N < 2)) begin : g_bad_n
    $error("polar_encoder_stream: N must be a power of two and at least 2");
  end
  if (!is_pow2(P) || (P > N)) begin : g_bad_p
    $error("polar_encoder_stream: P must be a power of two no larger than N");
  end

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_frame, w_frame_nxt, w_bfly, w_src, w_perm;
  logic [BW-1:0] r_beat, w_beat_nxt;
  logic [SW-1:0] r_stage, w_stage_nxt;
  logic [P-1:0]  r_out_data, w_out_data_nxt;
  logic          r_out_valid, w_out_valid_nxt;
  logic          r_out_last, w_out_last_nxt;
  logic          r_in_ready, w_in_ready_nxt;
  logic          r_frame_err, w_frame_err_nxt;
  logic          w_in_fire, w_out_fire;

  polar_butterfly_stage #(.N(N), .SW(SW)) u_bfly (
    .i_x     (r_frame),
    .i_stage (r_stage),
    .o_x     (w_bfly)
  );

  // On the last ENC cycle the finished codeword is still on the butterfly
  // output, so beat 0 is taken from there rather than from r_frame.
  assign w_src = (r_state == ENC) ? w_bfly : r_frame;

  for (genvar gi = 0; gi < N; gi++) begin : g_perm
    localparam int SRC = (BITREV != 0) ? int'(bitrev_n(gi, NST)) : gi;
    assign w_perm[gi] = w_src[SRC];
  end

  assign w_in_fire  = r_in_ready & i_in_valid;
  assign w_out_fire = r_out_valid & i_out_ready;

  // Next-state, counter, frame and registered-output computation.
  always_comb begin
    w_state_nxt     = r_state;
    w_frame_nxt     = r_frame;
    w_beat_nxt      = r_beat;
    w_stage_nxt     = r_stage;
    w_frame_err_nxt = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_in_fire) begin
          w_frame_nxt[int'(r_beat)*P +: P] = i_in_data;
          w_frame_err_nxt = i_in_last ^ (r_beat == LAST_BEAT);
          if (r_beat == LAST_BEAT) begin
            w_beat_nxt  = {BW{1'b0}};
            w_state_nxt = ENC;
          end else begin
            w_beat_nxt = r_beat + BW'(1);
          end
        end else begin
          w_beat_nxt = r_beat;
        end
      end
      ENC: begin
        w_frame_nxt = w_bfly;
        if (r_stage == LAST_STAGE) begin
          w_stage_nxt = {SW{1'b0}};
          w_beat_nxt  = {BW{1'b0}};
          w_state_nxt = OUT;
        end else begin
          w_stage_nxt = r_stage + SW'(1);
        end
      end
      OUT: begin
        if (w_out_fire) begin
          if (r_beat == LAST_BEAT) begin
            w_beat_nxt  = {BW{1'b0}};
            w_state_nxt = LOAD;
          end else begin
            w_beat_nxt = r_beat + BW'(1);
          end
        end else begin
          w_beat_nxt = r_beat;
        end
      end
      default: begin
        w_state_nxt = LOAD;
        w_beat_nxt  = {BW{1'b0}};
        w_stage_nxt = {SW{1'b0}};
      end
    endcase
    w_in_ready_nxt  = (w_state_nxt == LOAD);
    w_out_valid_nxt = (w_state_nxt == OUT);
    w_out_last_nxt  = (w_state_nxt == OUT) && (w_beat_nxt == LAST_BEAT);
    w_out_data_nxt  = w_out_valid_nxt ? w_perm[int'(w_beat_nxt)*P +: P] : {P{1'b0}};
  end

  // State, frame and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= LOAD;
      r_frame     <= {N{1'b0}};
      r_beat      <= {BW{1'b0}};
      r_stage     <= {SW{1'b0}};
      r_out_data  <= {P{1'b0}};
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame     <= w_frame_nxt;
      r_beat      <= w_beat_nxt;
      r_stage     <= w_stage_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_polar_encoder_stream.sv
// -----------------------------------------------------------------------------
// tb_polar_encoder_stream
// Self-checking bench: four encoder instances (N=8/P=4 natural and
// bit-reversed, N=32/P=32, N=32/P=1) checked against a reference model that
// evaluates the superset-XOR encoding rule directly.
// -----------------------------------------------------------------------------
module tb_polar_encoder_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int a_ferr = 0;

  always #5 clk = ~clk;

  // free-running cycle counter for timing checks
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]  a_in_data = 4'd0, b_in_data = 4'd0;
  logic [31:0] c_in_data = 32'd0;
  logic [0:0]  d_in_data = 1'b0;
  logic a_in_valid = 1'b0, a_in_last = 1'b0, a_out_ready = 1'b0;
  logic b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b0;
  logic c_in_valid = 1'b0, c_in_last = 1'b0, c_out_ready = 1'b0;
  logic d_in_valid = 1'b0, d_in_last = 1'b0, d_out_ready = 1'b0;
  logic [3:0]  a_out_data, b_out_data;
  logic [31:0] c_out_data;
  logic [0:0]  d_out_data;
  logic a_in_ready, a_out_valid, a_out_last, a_frame_err;
  logic b_in_ready, b_out_valid, b_out_last, b_frame_err;
  logic c_in_ready, c_out_valid, c_out_last, c_frame_err;
  logic d_in_ready, d_out_valid, d_out_last, d_frame_err;

  // counts cycles with frame_err high on the natural-order N=8 instance
  always @(posedge clk) if (a_frame_err) a_ferr <= a_ferr + 1;

  polar_encoder_stream #(.N(8), .P(4), .BITREV(0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_data(a_in_data), .i_in_valid(a_in_valid),
    .i_in_last(a_in_last), .o_in_ready(a_in_ready), .o_out_data(a_out_data),
    .o_out_valid(a_out_valid), .o_out_last(a_out_last), .i_out_ready(a_out_ready),
    .o_frame_err(a_frame_err));

  polar_encoder_stream #(.N(8), .P(4), .BITREV(1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_data(b_in_data), .i_in_valid(b_in_valid),
    .i_in_last(b_in_last), .o_in_ready(b_in_ready), .o_out_data(b_out_data),
    .o_out_valid(b_out_valid), .o_out_last(b_out_last), .i_out_ready(b_out_ready),
    .o_frame_err(b_frame_err));

  polar_encoder_stream #(.N(32), .P(32), .BITREV(0)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_data(c_in_data), .i_in_valid(c_in_valid),
    .i_in_last(c_in_last), .o_in_ready(c_in_ready), .o_out_data(c_out_data),
    .o_out_valid(c_out_valid), .o_out_last(c_out_last), .i_out_ready(c_out_ready),
    .o_frame_err(c_frame_err));

  polar_encoder_stream #(.N(32), .P(1), .BITREV(0)) u_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_data(d_in_data), .i_in_valid(d_in_valid),
    .i_in_last(d_in_last), .o_in_ready(d_in_ready), .o_out_data(d_out_data),
    .o_out_valid(d_out_valid), .o_out_last(d_out_last), .i_out_ready(d_out_ready),
    .o_frame_err(d_frame_err));

  // x[i] = XOR of u[j] over every j that contains all set bits of i
  function automatic logic [31:0] ref_encode(input int n, input logic [31:0] u);
    logic [31:0] x = 32'd0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        if ((i & j) == i) x[i] = x[i] ^ u[j];
    return x;
  endfunction

  // output position i carries x[reverse of i over nbits bits]
  function automatic logic [31:0] ref_bitrev(input int n, input int nbits, input logic [31:0] x);
    logic [31:0] y = 32'd0;
    for (int i = 0; i < n; i++) begin
      int r = 0;
      int t = i;
      for (int k = 0; k < nbits; k++) begin
        r = r * 2 + (t % 2);
        t = t / 2;
      end
      y[i] = x[r];
    end
    return y;
  endfunction

  task automatic a_load(input logic [7:0] u, input logic [1:0] lastp, output int t_acc);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_data  = u[b*4 +: 4];
      a_in_last  = lastp[b];
      for (int g = 0; g < 200 && !a_in_ready; g++) @(negedge clk);
      if (!a_in_ready) begin
        checks++; errors++;
        $display("FAIL a_load_timeout in_ready=%0b required=1", a_in_ready);
      end
    end
    t_acc = cyc;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic a_drain(input int stall_pct, output logic [7:0] y, output int lat,
                         output int hold_bad, output int last_bad, output int busy_ready,
                         output logic ready_after);
    int beat = 0;
    int g = 0;
    logic [3:0] pd = 4'd0;
    logic pl = 1'b0;
    logic pstall = 1'b0;
    y = 8'd0; lat = 1; hold_bad = 0; last_bad = 0; busy_ready = 0;
    while (!a_out_valid && g < 100) begin
      if (a_in_ready) busy_ready++;
      @(negedge clk);
      lat++; g++;
    end
    while (beat < 2 && g < 500) begin
      if (a_in_ready) busy_ready++;
      if (a_out_valid) begin
        if (pstall && ((a_out_data !== pd) || (a_out_last !== pl))) hold_bad++;
        if (a_out_last !== (beat == 1)) last_bad++;
        a_out_ready = ($urandom_range(99) >= stall_pct);
        if (a_out_ready) begin
          y[beat*4 +: 4] = a_out_data;
          beat++;
          pstall = 1'b0;
        end else begin
          pstall = 1'b1;
          pd = a_out_data;
          pl = a_out_last;
        end
      end
      @(negedge clk);
      g++;
    end
    a_out_ready = 1'b0;
    if (beat < 2) begin
      checks++; errors++;
      $display("FAIL a_drain_timeout beats=%0d required=2", beat);
    end
    ready_after = a_in_ready && !a_out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_in_ready, a_out_valid, a_out_last, a_out_data, a_frame_err} !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%0b vld=%0b last=%0b data=%h err=%0b required all 0",
               a_in_ready, a_out_valid, a_out_last, a_out_data, a_frame_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %0b required 1", a_in_ready);
    end
  endtask

  task automatic test_known_vectors();
    logic [7:0] us [3] = '{8'h01, 8'h80, 8'hFF};
    logic [7:0] xs [3] = '{8'h01, 8'hFF, 8'h80};
    logic [7:0] y; int t, lat, hb, lb, br; logic ra; int f0;
    f0 = a_ferr;
    for (int i = 0; i < 3; i++) begin
      a_load(us[i], 2'b10, t);
      a_drain(0, y, lat, hb, lb, br, ra);
      checks++;
      if (y !== xs[i]) begin errors++; $display("FAIL vector_cw u=%h got %h required %h", us[i], y, xs[i]); end
      checks++;
      if (lat != 4) begin errors++; $display("FAIL vector_latency got %0d required 4", lat); end
      checks++;
      if (lb != 0) begin errors++; $display("FAIL vector_out_last got %0d bad beats required 0", lb); end
      checks++;
      if (ra !== 1'b1) begin errors++; $display("FAIL vector_ready_after got %0b required 1", ra); end
    end
    checks++;
    if (a_ferr != f0) begin errors++; $display("FAIL vector_no_frame_err got %0d pulses required 0", a_ferr - f0); end
  endtask

  task automatic test_bitrev();
    logic [7:0] u, y;
    logic [31:0] nat, exp;
    for (int f = 0; f < 5; f++) begin
      u = (f == 0) ? 8'h02 : 8'($urandom);
      for (int b = 0; b < 2; b++) begin
        @(negedge clk);
        b_in_valid = 1'b1; b_in_data = u[b*4 +: 4]; b_in_last = (b == 1);
        for (int g = 0; g < 200 && !b_in_ready; g++) @(negedge clk);
      end
      @(negedge clk);
      b_in_valid = 1'b0; b_out_ready = 1'b1;
      for (int g = 0; g < 100 && !b_out_valid; g++) @(negedge clk);
      y = 8'd0;
      for (int k = 0; k < 2; k++) begin
        if (k > 0) @(negedge clk);
        y[k*4 +: 4] = b_out_valid ? b_out_data : 4'hx;
      end
      nat = ref_encode(8, {24'd0, u});
      exp = ref_bitrev(8, 3, nat);
      checks++;
      if (y !== exp[7:0]) begin errors++; $display("FAIL bitrev_cw u=%h got %h required %h", u, y, exp[7:0]); end
    end
    b_out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] u, y; logic [31:0] exp; int t, lat, hb, lb, br; logic ra;
    for (int f = 0; f < 3; f++) begin
      u = 8'($urandom);
      exp = ref_encode(8, {24'd0, u});
      a_load(u, 2'b10, t);
      a_drain(50, y, lat, hb, lb, br, ra);
      checks++;
      if (y !== exp[7:0]) begin errors++; $display("FAIL bp_cw u=%h got %h required %h", u, y, exp[7:0]); end
      checks++;
      if (hb != 0) begin errors++; $display("FAIL bp_hold got %0d unstable stalls required 0", hb); end
      checks++;
      if (lb != 0) begin errors++; $display("FAIL bp_out_last got %0d bad beats required 0", lb); end
      checks++;
      if (br != 0) begin errors++; $display("FAIL bp_in_ready_busy got %0d cycles required 0", br); end
      checks++;
      if (ra !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %0b required 1", ra); end
    end
  endtask

  task automatic test_framing();
    logic [7:0] u, y; logic [31:0] exp; int t, lat, hb, lb, br; logic ra; int f0;
    f0 = a_ferr;
    u = 8'h5A;
    exp = ref_encode(8, {24'd0, u});
    a_load(u, 2'b11, t);
    a_drain(0, y, lat, hb, lb, br, ra);
    checks++;
    if (a_ferr - f0 != 1) begin errors++; $display("FAIL framing_early_last got %0d pulse cycles required 1", a_ferr - f0); end
    checks++;
    if (y !== exp[7:0]) begin errors++; $display("FAIL framing_cw got %h required %h", y, exp[7:0]); end
    u = 8'h3C;
    exp = ref_encode(8, {24'd0, u});
    a_load(u, 2'b00, t);
    a_drain(0, y, lat, hb, lb, br, ra);
    checks++;
    if (a_ferr - f0 != 2) begin errors++; $display("FAIL framing_missing_last got %0d pulse cycles required 2", a_ferr - f0); end
    checks++;
    if (y !== exp[7:0]) begin errors++; $display("FAIL framing_cw2 got %h required %h", y, exp[7:0]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] u, y; logic [31:0] exp; int t, lat, hb, lb, br; logic ra;
    for (int m = 0; m < 2; m++) begin
      a_load(8'h80, 2'b10, t);
      if (m == 0) begin
        @(negedge clk);
      end else begin
        for (int g = 0; g < 100 && !a_out_valid; g++) @(negedge clk);
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({a_in_ready, a_out_valid, a_out_last, a_out_data, a_frame_err} !== 8'd0) begin
        errors++;
        $display("FAIL reset_mid%0d_outputs got rdy=%0b vld=%0b last=%0b data=%h err=%0b required all 0",
                 m, a_in_ready, a_out_valid, a_out_last, a_out_data, a_frame_err);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_mid%0d_ready got %0b required 1", m, a_in_ready); end
      u = 8'($urandom);
      exp = ref_encode(8, {24'd0, u});
      a_load(u, 2'b10, t);
      a_drain(0, y, lat, hb, lb, br, ra);
      checks++;
      if (y !== exp[7:0]) begin errors++; $display("FAIL reset_mid%0d_cw u=%h got %h required %h", m, u, y, exp[7:0]); end
    end
  endtask

  task automatic test_random_n32p32();
    logic [31:0] u, exp; int t; int prev_t = -1;
    c_out_ready = 1'b1;
    for (int f = 0; f < 200; f++) begin
      u = $urandom;
      @(negedge clk);
      c_in_valid = 1'b1; c_in_data = u; c_in_last = 1'b1;
      for (int g = 0; g < 100 && !c_in_ready; g++) @(negedge clk);
      t = cyc;
      if (prev_t >= 0) begin
        checks++;
        if (t - prev_t != 7) begin errors++; $display("FAIL p32_period got %0d required 7", t - prev_t); end
      end
      prev_t = t;
      @(negedge clk);
      c_in_valid = 1'b0;
      for (int g = 0; g < 100 && !c_out_valid; g++) @(negedge clk);
      exp = ref_encode(32, u);
      checks++;
      if (!c_out_valid || c_out_data !== exp || c_out_last !== 1'b1) begin
        errors++;
        $display("FAIL p32_cw u=%h got %h last=%0b required %h last=1", u, c_out_data, c_out_last, exp);
      end
    end
    c_out_ready = 1'b0;
  endtask

  task automatic test_random_n32p1();
    logic [31:0] u, y, exp; int t; int prev_t = -1; int lb;
    d_out_ready = 1'b1;
    for (int f = 0; f < 200; f++) begin
      u = $urandom;
      for (int b = 0; b < 32; b++) begin
        @(negedge clk);
        d_in_valid = 1'b1; d_in_data = u[b]; d_in_last = (b == 31);
        for (int g = 0; g < 100 && !d_in_ready; g++) @(negedge clk);
      end
      t = cyc;
      if (prev_t >= 0) begin
        checks++;
        if (t - prev_t != 69) begin errors++; $display("FAIL p1_period got %0d required 69", t - prev_t); end
      end
      prev_t = t;
      @(negedge clk);
      d_in_valid = 1'b0; d_in_last = 1'b0;
      for (int g = 0; g < 100 && !d_out_valid; g++) @(negedge clk);
      y = 32'd0; lb = 0;
      for (int k = 0; k < 32; k++) begin
        if (k > 0) @(negedge clk);
        y[k] = d_out_valid ? d_out_data[0] : 1'bx;
        if (d_out_last !== (k == 31)) lb++;
      end
      exp = ref_encode(32, u);
      checks++;
      if (y !== exp) begin errors++; $display("FAIL p1_cw u=%h got %h required %h", u, y, exp); end
      checks++;
      if (lb != 0) begin errors++; $display("FAIL p1_out_last got %0d bad beats required 0", lb); end
    end
    d_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_bitrev();
    test_backpressure();
    test_framing();
    test_reset_mid();
    test_random_n32p32();
    test_random_n32p1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
